// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC register, combinational imem address, small {pc,instr} FIFO toward decode.
// Optional misaligned-redirect trap is compiled in with FETCH_ALIGN_CHECK_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        fetch_fault
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [0:0] {RUN = 1'b0, FAULT = 1'b1} state_t;
`else
    typedef enum logic [0:0] {RUN = 1'b0} state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic [31:0]       pc;
    logic [31:0]       pc_next;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       mem_pc    [FIFO_DEPTH];
    logic [31:0]       mem_instr [FIFO_DEPTH];
    logic              push;
    logic              pop;
    logic              full;
    logic              misaligned;

    assign imem_addr  = pc;
    assign out_valid  = (count != '0);
    assign out_instr  = out_valid ? mem_instr[rd_ptr] : NOP_INSTR;
    assign out_pc     = out_valid ? mem_pc[rd_ptr]    : 32'h0000_0000;
    assign misaligned = (redirect_pc[1:0] != 2'b00);

`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = (state == FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        pop        = out_valid & out_ready;
        full       = (count == DEPTH_CNT);
        push       = (state == RUN) && !redirect_valid && (!full || pop);
        if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            // A misaligned target is kept verbatim so the faulting address stays visible.
            state_next = misaligned ? FAULT : RUN;
            pc_next    = misaligned ? redirect_pc : (redirect_pc & 32'hFFFF_FFFC);
`else
            state_next = RUN;
            pc_next    = redirect_pc & 32'hFFFF_FFFC;
`endif
        end else if (push) begin
            pc_next = pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (redirect_valid) begin
                // Flush wins over any same-cycle push; a same-cycle pop was already consumed.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // Buffer storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= pc;
            mem_instr[wr_ptr] <= imem_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, streaming, backpressure, redirect/flush, alignment, wrap, reset mid-stream.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        fetch_fault;

    logic [31:0] mem [64];
    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int pops0;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:2]];

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) pops <= pops + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h00A0_0513;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'h0000_0013);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

        // streaming with decode always ready
        rst = 1'b0;
        out_ready = 1'b1;
        chk("t1_addr0", imem_addr, 32'h0);
        tick();
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_pc0", out_pc, 32'h0);
        chk("t1_instr0", out_instr, 32'h00A0_0513);
        chk("t1_addr4", imem_addr, 32'h4);
        tick();
        chk("t1_pc4", out_pc, 32'h4);
        chk("t1_instr4", out_instr, 32'hA000_0001);
        chk("t1_addr8", imem_addr, 32'h8);

        // backpressure from reset: buffer fills with 0,4 and the PC parks at 8
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t2_valid", {31'b0, out_valid}, 32'd1);
        chk("t2_head", out_pc, 32'h0);
        chk("t2_addr_hold", imem_addr, 32'h8);
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t2_seq_valid", {31'b0, out_valid}, 32'd1);
            chk("t2_seq_pc", out_pc, 32'(4 * i));
        end

        // redirect while full
        out_ready = 1'b0;
        tick();
        chk("t3_full_addr", imem_addr, 32'd20);
        tick();
        chk("t3_full_addr2", imem_addr, 32'd20);
        redirect_to(32'h30);
        chk("t3_valid", {31'b0, out_valid}, 32'd0);
        chk("t3_addr", imem_addr, 32'h30);
        tick();
        chk("t3_head_pc", out_pc, 32'h30);
        chk("t3_head_instr", out_instr, 32'hA000_000C);

        // redirect with pop in flight and room to push
        out_ready = 1'b1;
        pops0 = pops;
        redirect_to(32'h80);
        chk("t4_pops", 32'(pops - pops0), 32'd1);
        chk("t4_valid", {31'b0, out_valid}, 32'd0);
        chk("t4_addr", imem_addr, 32'h80);
        tick();
        chk("t4_head", out_pc, 32'h80);
        tick();
        chk("t4_next", out_pc, 32'h84);

        // misaligned redirect
        redirect_to(32'h32);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t5_fault", {31'b0, fetch_fault}, 32'd1);
        chk("t5_addr", imem_addr, 32'h32);
        tick();
        tick();
        chk("t5_fault_hold", {31'b0, fetch_fault}, 32'd1);
        chk("t5_valid_hold", {31'b0, out_valid}, 32'd0);
        chk("t5_addr_hold", imem_addr, 32'h32);
`else
        chk("t5_fault", {31'b0, fetch_fault}, 32'd0);
        chk("t5_addr", imem_addr, 32'h30);
        tick();
        chk("t5_head", out_pc, 32'h30);
`endif
        redirect_to(32'h40);
        chk("t5_fault_clr", {31'b0, fetch_fault}, 32'd0);
        chk("t5_addr40", imem_addr, 32'h40);
        chk("t5_valid0", {31'b0, out_valid}, 32'd0);
        tick();
        chk("t5_head40", out_pc, 32'h40);

        // PC wraps past the top of the address space
        redirect_to(32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_head", out_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", out_instr, 32'hA000_003F);
        chk("wrap_addr0", imem_addr, 32'h0);

        // reset with two entries queued
        out_ready = 1'b0;
        tick();
        chk("t6_queued", {31'b0, out_valid}, 32'd1);
        chk("t6_addr", imem_addr, 32'h4);
        rst = 1'b1;
        tick();
        chk("t6_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_addr_rst", imem_addr, 32'h0);
        chk("t6_fault", {31'b0, fetch_fault}, 32'd0);
        chk("t6_instr", out_instr, 32'h0000_0013);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t6_restart_pc", out_pc, 32'h0);
        chk("t6_restart_instr", out_instr, 32'h00A0_0513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
